// File: rtl/ex_mem_stage_buf.sv
// Pipeline stage register with a 2-entry skid buffer. Ready to upstream is registered,
// a flush squashes everything in flight, and a saturating counter tracks output stalls.
module ex_mem_stage_buf #(
  parameter int unsigned CTRL_W         = 4,
  parameter int unsigned DATA_W         = 69,
  parameter int unsigned FLUSH_CLR_DATA = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The state value is the number of held entries, so it drives occupancy directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              st_q, st_d;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic [CNT_W-1:0]    stall_q;

  logic                main_vld, skid_vld;
  logic                in_xfer, out_xfer;
  logic                load_main_in, load_main_skid, load_skid;

  assign main_vld  = (st_q != EMPTY);
  assign skid_vld  = (st_q == FULL);
  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign out_ctrl  = main_vld ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = 2'(st_q);
  assign stall_cnt = stall_q;

  always_comb begin
    st_d           = st_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (st_q)
      EMPTY: begin
        if (in_xfer) begin
          st_d         = BUSY;
          load_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && !out_xfer) begin
          st_d      = FULL;
          load_skid = 1'b1;
        end else if (out_xfer && !in_xfer) begin
          st_d = EMPTY;
        end else if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (out_xfer) begin
          st_d           = BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: st_d = EMPTY;
    endcase
    // Flush wins over any transfer; an accepted input in this cycle is dropped.
    if (flush) begin
      st_d           = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (FLUSH_CLR_DATA != 0) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end
    end else begin
      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

  // Stall counter ignores flush; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: directed scenarios plus random traffic checked against
// a queue-based FIFO model. A second instance uses a 3-bit counter and keeps data on flush.
module tb_ex_mem_stage_buf;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 69;

  logic              clk, reset_n, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  logic              in_ready2, out_valid2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [DATA_W-1:0] out_data2;
  logic [1:0]        occupancy2;
  logic [2:0]        stall_cnt2;

  ex_mem_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_CLR_DATA(1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ex_mem_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_CLR_DATA(0), .CNT_W(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] hd1, hd2;
  int unsigned       sc1, sc2;
  int                checks = 0;
  int                errors = 0;
  int                model_pops = 0;
  int                dut_pops = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [CTRL_W-1:0] ec;
    ec = (mq.size() > 0) ? mq[0].c : '0;
    chk("in_ready",  128'(in_ready),   128'(mq.size() < 2));
    chk("out_valid", 128'(out_valid),  128'(mq.size() > 0));
    chk("out_ctrl",  128'(out_ctrl),   128'(ec));
    chk("out_data",  128'(out_data),   128'(hd1));
    chk("occupancy", 128'(occupancy),  128'(mq.size()));
    chk("stall_cnt", 128'(stall_cnt),  128'(sc1));
    chk("occ2",      128'(occupancy2), 128'(mq.size()));
    chk("out_data2", 128'(out_data2),  128'(hd2));
    chk("stall2",    128'(stall_cnt2), 128'(sc2));
  endtask

  task automatic model_reset();
    mq.delete();
    hd1 = '0;
    hd2 = '0;
    sc1 = 0;
    sc2 = 0;
  endtask

  // One clock cycle: drive inputs, advance model by FIFO rules, check just after the edge.
  task automatic step(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                      input logic ordy, input logic fl);
    bit ixf, oxf;
    ent_t e;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    ixf = iv && (mq.size() < 2);
    oxf = (mq.size() > 0) && ordy;
    if (mq.size() > 0 && !ordy) begin
      if (sc1 < 65535) sc1++;
      if (sc2 < 7) sc2++;
    end
    if (out_valid && out_ready) dut_pops++;
    @(posedge clk);
    if (fl) begin
      if (oxf) model_pops++;
      mq.delete();
      hd1 = '0;
    end else begin
      if (oxf) begin
        void'(mq.pop_front());
        model_pops++;
      end
      if (ixf) begin
        e.c = ic;
        e.d = id;
        mq.push_back(e);
      end
      if (mq.size() > 0) begin
        hd1 = mq[0].d;
        hd2 = mq[0].d;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [95:0] r;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    model_reset();
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_occ",       128'(occupancy), 128'(0));
    chk("rst_stall",     128'(stall_cnt), 128'(0));
    do_reset();

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 4'b1011, DATA_W'(i), 1'b1, 1'b0);
      chk("stream_data", 128'(out_data), 128'(i));
      chk("stream_ctrl", 128'(out_ctrl), 128'(4'b1011));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stream_drain", 128'(out_valid), 128'(0));
    chk("stream_stall", 128'(stall_cnt), 128'(0));

    // Stall fills the skid buffer
    do_reset();
    step(1'b1, 4'h3, DATA_W'('hA), 1'b0, 1'b0);
    step(1'b1, 4'h5, DATA_W'('hB), 1'b0, 1'b0);
    chk("full_in_ready", 128'(in_ready), 128'(0));
    step(1'b1, 4'h7, DATA_W'('hC), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("full_occ",   128'(occupancy), 128'(2));
    chk("full_stall", 128'(stall_cnt), 128'(3));
    chk("full_head",  128'(out_data),  128'('hA));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain_head_b",  128'(out_data), 128'('hB));
    chk("drain_in_ready", 128'(in_ready), 128'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain_empty", 128'(out_valid), 128'(0));

    // Flush while full, with an input offered
    do_reset();
    step(1'b1, 4'h3, DATA_W'('hA), 1'b0, 1'b0);
    step(1'b1, 4'h5, DATA_W'('hB), 1'b0, 1'b0);
    step(1'b1, 4'h9, DATA_W'('hD), 1'b0, 1'b1);
    chk("flush_valid", 128'(out_valid),  128'(0));
    chk("flush_ctrl",  128'(out_ctrl),   128'(0));
    chk("flush_occ",   128'(occupancy),  128'(0));
    chk("flush_rdy",   128'(in_ready),   128'(1));
    chk("flush_data",  128'(out_data),   128'(0));
    chk("flush_keep",  128'(out_data2),  128'('hA));
    flush = 1'b0;

    // Stall counter saturation on the 3-bit instance
    do_reset();
    step(1'b1, 4'h1, DATA_W'('h55), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_cnt3",  128'(stall_cnt2), 128'(7));
    chk("sat_cnt16", 128'(stall_cnt),  128'(10));

    // Random traffic
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      step(1'($urandom_range(0, 1)), CTRL_W'($urandom()), r[DATA_W-1:0],
           1'($urandom_range(0, 3) != 0 ? 1 : 0), 1'($urandom_range(0, 49) == 0));
    end
    chk("rand_pops", 128'(dut_pops), 128'(model_pops));

    // Asynchronous reset between edges while full
    do_reset();
    step(1'b1, 4'h2, DATA_W'('h11), 1'b0, 1'b0);
    step(1'b1, 4'h4, DATA_W'('h22), 1'b0, 1'b0);
    chk("pre_arst_occ", 128'(occupancy), 128'(2));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_ctrl",  128'(out_ctrl),  128'(0));
    chk("arst_data",  128'(out_data),  128'(0));
    chk("arst_occ",   128'(occupancy), 128'(0));
    chk("arst_rdy",   128'(in_ready),  128'(1));
    chk("arst_stall", 128'(stall_cnt), 128'(0));
    model_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 4'h6, DATA_W'('h33), 1'b1, 1'b0);
    chk("post_arst_data", 128'(out_data), 128'('h33));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
